tap_controller: RTL and testbench
=================================

Name: tap_controller

Overview:
- IEEE 1149.1 TAP sequencer for the JTAG data-register block.
- Contains:
  - the 16-state TAP FSM, driven by TMS;
  - the instruction register, with its shift stage and latched stage;
  - the 1-bit BYPASS register;
  - the negedge TDO output stage.
- Generates TLR, CAPTURE_DR, SHIFT_DR and UPDATE_DR, plus the latched instruction consumed by the DR block.
- Selects which DR serial output (ID, USER, BSR or BYPASS) is driven onto TDO.

Parameters:
- IR_WIDTH, 4, instruction register width.
- IR_CAPTURE, 4'b0001, value loaded into the IR shift stage in Capture-IR (the two LSBs must be 01).
- IR_RESET, `IDCODE, value of LATCH_IR after reset and in Test-Logic-Reset.

Ports:
- TCK  in  1  test clock.
- TRST  in  1  reset, asynchronous, active-low.
- TMS  in  1  mode select, sampled on rising TCK.
- TDI  in  1  serial data in.
- ID_TDO  in  1  serial out of the ID register.
- USER_TDO  in  1  serial out of the USER register.
- BSR_TDO  in  1  serial out of the boundary-scan register.
- TDO  out  1  serial data out.
- TDO_EN  out  1  high while shifting (pad output enable).
- TLR  out  1  FSM is in Test-Logic-Reset.
- CAPTURE_DR  out  1  FSM is in Capture-DR.
- SHIFT_DR  out  1  FSM is in Shift-DR.
- UPDATE_DR  out  1  FSM is in Update-DR.
- RUN_IDLE  out  1  FSM is in Run-Test/Idle.
- LATCH_IR  out  IR_WIDTH  current instruction.
- TAP_STATE  out  4  state encoding, for debug and verification.

Behaviour:

FSM
- States: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
- Encoding: 4'h0 through 4'hF in the listed order; exported on TAP_STATE.
- Transitions follow IEEE 1149.1 on rising TCK:
  - TLR: TMS=0 -> RTI, TMS=1 -> stay.
  - RTI: 1 -> SEL_DR, 0 -> stay.
  - SEL_DR: 0 -> CAP_DR, 1 -> SEL_IR.
  - SEL_IR: 0 -> CAP_IR, 1 -> TLR.
  - CAP_x: 0 -> SH_x, 1 -> EX1_x.
  - SH_x: 0 -> stay, 1 -> EX1_x.
  - EX1_x: 0 -> PA_x, 1 -> UPD_x.
  - PA_x: 0 -> stay, 1 -> EX2_x.
  - EX2_x: 0 -> SH_x, 1 -> UPD_x.
  - UPD_x: 0 -> RTI, 1 -> SEL_DR (both DR and IR paths).
- Five consecutive TMS=1 clocks reach TLR from any state.

Resets
- TRST low asynchronously forces:
  - state = TLR;
  - IR shift stage = IR_CAPTURE;
  - LATCH_IR = IR_RESET;
  - bypass = 0;
  - TDO = 0;
  - TDO_EN = 0.
- TRST is legal at any point, including mid-shift; no partial IR update survives it.
- While in TLR (synchronous path), LATCH_IR is held at IR_RESET.

Decoded outputs
- TLR, CAPTURE_DR, SHIFT_DR, UPDATE_DR and RUN_IDLE are combinational decodes of the state register.
- Each is therefore high for exactly the TCK period spent in that state, so the DR block acts on the rising edge that leaves the state.
- Reset values: TLR=1, all others 0.

IR path (rising TCK)
- In CAP_IR: IR shift stage <= IR_CAPTURE.
- In SH_IR: IR shift stage <= {TDI, ir_sh[IR_WIDTH-1:1]} (LSB first).
- PA_IR and EX states hold the shift stage.
- LATCH_IR loads the shift stage on the falling TCK edge while in UPD_IR.
- LATCH_IR is otherwise stable, and never changes during a DR scan.

Bypass register (rising TCK)
- CAP_DR: 0.
- SH_DR: TDI.
- Updated only when the decoded selection is BYPASS.

TDO mux
- In SH_IR: ir_sh[0].
- In SH_DR, by LATCH_IR:
  - IDCODE -> ID_TDO;
  - USERCODE -> USER_TDO;
  - SAMPLE, EXTEST, INTEST -> BSR_TDO;
  - BYPASS, CLAMP, HIGHZ, RUNBIST and any undefined code -> bypass.
- In all other states: 0.

TDO stage (falling TCK)
- TDO <= mux output.
- TDO_EN <= (state == SH_DR) | (state == SH_IR).
- Result: TDO is valid half a period after entering a shift state and is held through the following rising edge.

Decomposition:
- Shared package (extend IR_DEFINES) holds:
  - opcodes: EXTEST=4'h0, SAMPLE=4'h1, INTEST=4'h2, RUNBIST=4'h3, CLAMP=4'h4, IDCODE=4'h5, USERCODE=4'h6, HIGHZ=4'h7, BYPASS=4'hF;
  - the 16 TAP state constants.
- One natural sub-module, tap_fsm: state register, next-state logic and output decodes.
- Kept in tap_controller: IR, bypass register and TDO stage.

Test Plan:
- Reset: pulse TRST low mid-SH_DR -> state=TLR, LATCH_IR=4'h5, TDO_EN=0, TDO=0, TLR=1, all with no TCK edge.
- TMS walk: from each of the 16 states apply TMS=1 for 5 TCKs -> TAP_STATE=4'h0. Separately apply TMS sequence 0,1,0,0 from TLR -> RTI, SEL_DR, CAP_DR, SH_DR, with CAPTURE_DR high for exactly one period.
- IR load: scan 4'h6 LSB-first through SH_IR -> TDO shows 1,0,0,0 (IR_CAPTURE). LATCH_IR becomes 4'h6 on the falling edge in UPD_IR and not earlier.
- Bypass: load 4'hF, scan DR with TDI=1,0,1,1 -> TDO = 0,1,0,1 (one-bit delay with captured 0).
- Instruction routing: under IDCODE, TDO follows ID_TDO. Under EXTEST, TDO follows BSR_TDO. Under undefined 4'hA, TDO follows bypass.
- Pause/resume: in SH_DR go EX1_DR, PA_DR (2 cycles), EX2_DR, SH_DR -> SHIFT_DR=0 and TDO_EN=0 during pause; shifting resumes with no bit lost.

Source files
------------

// File: rtl/tap_controller_pkg.sv
// Shared JTAG definitions: instruction opcodes and TAP state encoding.
package tap_controller_pkg;

  localparam logic [3:0] EXTEST   = 4'h0;
  localparam logic [3:0] SAMPLE   = 4'h1;
  localparam logic [3:0] INTEST   = 4'h2;
  localparam logic [3:0] RUNBIST  = 4'h3;
  localparam logic [3:0] CLAMP    = 4'h4;
  localparam logic [3:0] IDCODE   = 4'h5;
  localparam logic [3:0] USERCODE = 4'h6;
  localparam logic [3:0] HIGHZ    = 4'h7;
  localparam logic [3:0] BYPASS   = 4'hF;

  typedef enum logic [3:0] {
    StTlr   = 4'h0,
    StRti   = 4'h1,
    StSelDr = 4'h2,
    StCapDr = 4'h3,
    StShDr  = 4'h4,
    StEx1Dr = 4'h5,
    StPaDr  = 4'h6,
    StEx2Dr = 4'h7,
    StUpdDr = 4'h8,
    StSelIr = 4'h9,
    StCapIr = 4'hA,
    StShIr  = 4'hB,
    StEx1Ir = 4'hC,
    StPaIr  = 4'hD,
    StEx2Ir = 4'hE,
    StUpdIr = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DrId,
    DrUser,
    DrBsr,
    DrBypass
  } dr_sel_e;

endpackage

// File: rtl/tap_controller_fsm.sv
// IEEE 1149.1 TAP state machine with combinational state decodes.
module tap_fsm
  import tap_controller_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_e tap_state,
  output logic       TLR,
  output logic       CAPTURE_DR,
  output logic       SHIFT_DR,
  output logic       UPDATE_DR,
  output logic       RUN_IDLE
);

  tap_state_e state_q, state_d;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q <= StTlr;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:   state_d = TMS ? StTlr   : StRti;
      StRti:   state_d = TMS ? StSelDr : StRti;
      StSelDr: state_d = TMS ? StSelIr : StCapDr;
      StCapDr: state_d = TMS ? StEx1Dr : StShDr;
      StShDr:  state_d = TMS ? StEx1Dr : StShDr;
      StEx1Dr: state_d = TMS ? StUpdDr : StPaDr;
      StPaDr:  state_d = TMS ? StEx2Dr : StPaDr;
      StEx2Dr: state_d = TMS ? StUpdDr : StShDr;
      StUpdDr: state_d = TMS ? StSelDr : StRti;
      StSelIr: state_d = TMS ? StTlr   : StCapIr;
      StCapIr: state_d = TMS ? StEx1Ir : StShIr;
      StShIr:  state_d = TMS ? StEx1Ir : StShIr;
      StEx1Ir: state_d = TMS ? StUpdIr : StPaIr;
      StPaIr:  state_d = TMS ? StEx2Ir : StPaIr;
      StEx2Ir: state_d = TMS ? StUpdIr : StShIr;
      StUpdIr: state_d = TMS ? StSelDr : StRti;
    endcase
  end

  assign tap_state  = state_q;
  assign TLR        = (state_q == StTlr);
  assign CAPTURE_DR = (state_q == StCapDr);
  assign SHIFT_DR   = (state_q == StShDr);
  assign UPDATE_DR  = (state_q == StUpdDr);
  assign RUN_IDLE   = (state_q == StRti);

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP sequencer: FSM, instruction register, bypass register and negedge TDO stage.
module tap_controller
  import tap_controller_pkg::*;
#(
  parameter int unsigned         IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(4'b0001),
  parameter logic [IR_WIDTH-1:0] IR_RESET   = IR_WIDTH'(IDCODE)
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                ID_TDO,
  input  logic                USER_TDO,
  input  logic                BSR_TDO,
  output logic                TDO,
  output logic                TDO_EN,
  output logic                TLR,
  output logic                CAPTURE_DR,
  output logic                SHIFT_DR,
  output logic                UPDATE_DR,
  output logic                RUN_IDLE,
  output logic [IR_WIDTH-1:0] LATCH_IR,
  output logic [3:0]          TAP_STATE
);

  tap_state_e          state;
  logic [IR_WIDTH-1:0] ir_sh_q;
  logic [IR_WIDTH-1:0] latch_ir_q;
  logic                bypass_q;
  logic                tdo_q, tdo_en_q;
  logic                tdo_mux;
  dr_sel_e             dr_sel;

  tap_fsm u_tap_fsm (
    .TCK        (TCK),
    .TRST       (TRST),
    .TMS        (TMS),
    .tap_state  (state),
    .TLR        (TLR),
    .CAPTURE_DR (CAPTURE_DR),
    .SHIFT_DR   (SHIFT_DR),
    .UPDATE_DR  (UPDATE_DR),
    .RUN_IDLE   (RUN_IDLE)
  );

  always_comb begin
    dr_sel = DrBypass;
    case (latch_ir_q)
      IR_WIDTH'(IDCODE):   dr_sel = DrId;
      IR_WIDTH'(USERCODE): dr_sel = DrUser;
      IR_WIDTH'(SAMPLE),
      IR_WIDTH'(EXTEST),
      IR_WIDTH'(INTEST):   dr_sel = DrBsr;
      default:             dr_sel = DrBypass;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sh_q <= IR_CAPTURE;
    end else if (state == StCapIr) begin
      ir_sh_q <= IR_CAPTURE;
    end else if (state == StShIr) begin
      ir_sh_q <= {TDI, ir_sh_q[IR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      bypass_q <= 1'b0;
    end else if (dr_sel == DrBypass) begin
      if (state == StCapDr) begin
        bypass_q <= 1'b0;
      end else if (state == StShDr) begin
        bypass_q <= TDI;
      end
    end
  end

  always_comb begin
    tdo_mux = 1'b0;
    if (state == StShIr) begin
      tdo_mux = ir_sh_q[0];
    end else if (state == StShDr) begin
      unique case (dr_sel)
        DrId:     tdo_mux = ID_TDO;
        DrUser:   tdo_mux = USER_TDO;
        DrBsr:    tdo_mux = BSR_TDO;
        DrBypass: tdo_mux = bypass_q;
      endcase
    end
  end

  // Falling-edge stage: TDO and the latched instruction settle half a period
  // before the rising edge at which the DR block samples them.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
      latch_ir_q <= IR_RESET;
    end else begin
      tdo_q    <= tdo_mux;
      tdo_en_q <= (state == StShDr) || (state == StShIr);
      if (state == StTlr) begin
        latch_ir_q <= IR_RESET;
      end else if (state == StUpdIr) begin
        latch_ir_q <= ir_sh_q;
      end
    end
  end

  assign TDO       = tdo_q;
  assign TDO_EN    = tdo_en_q;
  assign LATCH_IR  = latch_ir_q;
  assign TAP_STATE = state;

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller against a table-driven TAP reference model.
module tb_tap_controller;

  logic       TCK = 1'b0;
  logic       TRST, TMS, TDI, ID_TDO, USER_TDO, BSR_TDO;
  logic       TDO, TDO_EN, TLR, CAPTURE_DR, SHIFT_DR, UPDATE_DR, RUN_IDLE;
  logic [3:0] LATCH_IR, TAP_STATE;

  tap_controller dut (
    .TCK        (TCK),
    .TRST       (TRST),
    .TMS        (TMS),
    .TDI        (TDI),
    .ID_TDO     (ID_TDO),
    .USER_TDO   (USER_TDO),
    .BSR_TDO    (BSR_TDO),
    .TDO        (TDO),
    .TDO_EN     (TDO_EN),
    .TLR        (TLR),
    .CAPTURE_DR (CAPTURE_DR),
    .SHIFT_DR   (SHIFT_DR),
    .UPDATE_DR  (UPDATE_DR),
    .RUN_IDLE   (RUN_IDLE),
    .LATCH_IR   (LATCH_IR),
    .TAP_STATE  (TAP_STATE)
  );

  always #5 TCK = ~TCK;

  typedef struct {
    logic [3:0] st;
    logic [4:0] dec;  // {TLR, CAPTURE_DR, SHIFT_DR, UPDATE_DR, RUN_IDLE}
    logic [3:0] latch_pos;
    logic       tdo_pos, en_pos;
    logic [3:0] latch_neg;
    logic       tdo_neg, en_neg;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   running = 0;

  // Next state indexed by current state, for TMS=0 and TMS=1.
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  // Reference model state.
  int m_st, m_ir, m_latch;
  bit m_byp, m_tdo, m_en;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // 0 = ID, 1 = USER, 2 = BSR, 3 = bypass
  function automatic int dr_src(input int op);
    if (op == 5) return 0;
    if (op == 6) return 1;
    if (op == 0 || op == 1 || op == 2) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ir = 1; m_latch = 5; m_byp = 0; m_tdo = 0; m_en = 0;
  endtask

  // One TCK period: drive inputs, advance the model, queue expected outputs.
  task automatic step(input bit tms, input bit tdi);
    exp_t e;
    bit   id, us, bs, src_bit;
    id = 1'($urandom); us = 1'($urandom); bs = 1'($urandom);
    TMS = tms; TDI = tdi; ID_TDO = id; USER_TDO = us; BSR_TDO = bs;
    e.latch_pos = 4'(m_latch); e.tdo_pos = m_tdo; e.en_pos = m_en;
    if (m_st == 10) m_ir = 1;
    else if (m_st == 11) m_ir = (m_ir >> 1) | (int'(tdi) << 3);
    if (dr_src(m_latch) == 3) begin
      if (m_st == 3) m_byp = 0;
      else if (m_st == 4) m_byp = tdi;
    end
    m_st = tms ? nxt1[m_st] : nxt0[m_st];
    e.st  = 4'(m_st);
    e.dec = {m_st == 0, m_st == 3, m_st == 4, m_st == 8, m_st == 1};
    case (dr_src(m_latch))
      0: src_bit = id;
      1: src_bit = us;
      2: src_bit = bs;
      default: src_bit = m_byp;
    endcase
    if (m_st == 11) m_tdo = m_ir[0];
    else if (m_st == 4) m_tdo = src_bit;
    else m_tdo = 0;
    m_en = (m_st == 4) || (m_st == 11);
    if (m_st == 0) m_latch = 5;
    else if (m_st == 15) m_latch = m_ir;
    e.latch_neg = 4'(m_latch); e.tdo_neg = m_tdo; e.en_neg = m_en;
    q.push_back(e);
    @(negedge TCK);
    #2;
  endtask

  // Asynchronous reset between edges; outputs must respond with no TCK edge.
  task automatic do_reset();
    TRST = 1'b0;
    #1;
    check("rst_state", TAP_STATE, 4'h0);
    check("rst_latch_ir", LATCH_IR, 4'h5);
    check("rst_tdo", TDO, 1'b0);
    check("rst_tdo_en", TDO_EN, 1'b0);
    check("rst_decodes", {TLR, CAPTURE_DR, SHIFT_DR, UPDATE_DR, RUN_IDLE}, 5'b10000);
    TRST = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic go_tlr();
    repeat (5) step(1'b1, 1'($urandom));
  endtask

  // From RTI, load an instruction and return to RTI.
  task automatic load_ir(input logic [3:0] val);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, val[i]);
    step(1, 0); step(0, 0);
  endtask

  // From RTI, shift n DR bits (LSB of bits first) and return to RTI.
  task automatic scan_dr(input logic [31:0] bits, input int n);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) step(i == n - 1, bits[i]);
    step(1, 0); step(0, 0);
  endtask

  // Monitor: pops one expectation per TCK period, checks both half-periods.
  initial begin
    exp_t e;
    forever begin
      @(posedge TCK);
      #1;
      if (!running) continue;
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty @%0t: got 0 entries expected 1", $time);
        continue;
      end
      e = q.pop_front();
      check("state", TAP_STATE, e.st);
      check("decodes", {TLR, CAPTURE_DR, SHIFT_DR, UPDATE_DR, RUN_IDLE}, e.dec);
      check("latch_ir_rise", LATCH_IR, e.latch_pos);
      check("tdo_rise", TDO, e.tdo_pos);
      check("tdo_en_rise", TDO_EN, e.en_pos);
      @(negedge TCK);
      #1;
      check("latch_ir_fall", LATCH_IR, e.latch_neg);
      check("tdo_fall", TDO, e.tdo_neg);
      check("tdo_en_fall", TDO_EN, e.en_neg);
    end
  end

  string paths[16] = '{"", "0", "01", "010", "0100", "0101", "01010", "010101", "01011",
                       "011", "0110", "01100", "01101", "011010", "0110101", "011011"};

  initial begin
    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; ID_TDO = 1'b0; USER_TDO = 1'b0; BSR_TDO = 1'b0;
    #1;
    do_reset();
    running = 1;

    // TLR -> RTI -> SEL_DR -> CAP_DR -> SH_DR, shift a little, reset mid-shift.
    step(0, 0); step(1, 0); step(0, 0); step(0, 1); step(0, 0); step(0, 1);
    do_reset();

    // Five TMS=1 clocks return to TLR from every state.
    for (int t = 0; t < 16; t++) begin
      go_tlr();
      for (int i = 0; i < paths[t].len(); i++) step(paths[t][i] == "1", 1'($urandom));
      go_tlr();
    end

    step(0, 0);
    load_ir(4'h6);
    load_ir(4'hF);
    scan_dr(32'b1101, 4);
    load_ir(4'h5);
    scan_dr($urandom, 8);
    load_ir(4'h0);
    scan_dr($urandom, 8);
    load_ir(4'hA);
    scan_dr($urandom, 8);

    // Pause/resume inside a bypass DR scan.
    load_ir(4'hF);
    step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(1, 1);
    step(0, 0); step(0, 0); step(1, 0); step(0, 0);
    step(0, 0); step(1, 1);
    step(1, 0); step(0, 0);

    // Random TMS/TDI walk with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 99) < 30, 1'($urandom));
    end

    running = 0;
    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
